// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the MDU scheduler state encoding for the 5-stage core.
package pipe_pkg;

  localparam logic [31:0] RESET_PC        = 32'h3000;
  localparam logic [4:0]  ZERO_REG        = 5'd0;
  localparam int          MDU_LAT_DEFAULT = 32;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Counter width that can hold the value lat itself
  function automatic int mdu_cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs from the pipeline and the hold/flush controls back to it.
interface hazard_ctrl_if #(
  parameter int PERF_W = 32
);

  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              ex_mem_read;
  logic [4:0]        ex_rt;
  logic              ex_branch_taken;
  logic              ex_mdu_start;
  logic              id_mdu_read;
  logic              id_mdu_op;

  logic              pc_stall;
  logic              if_stall;
  logic              if_flush;
  logic              id_ex_flush;
  logic              mdu_busy;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, ex_mdu_start, id_mdu_read, id_mdu_op,
    input  pc_stall, if_stall, if_flush, id_ex_flush, mdu_busy, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, ex_mdu_start, id_mdu_read, id_mdu_op,
    output pc_stall, if_stall, if_flush, id_ex_flush, mdu_busy, stall_cycles
  );

endinterface

// File: rtl/mdu_sched.sv
// MDU busy-window scheduler: loads MDU_LAT on a start pulse and counts down to idle.
//
// state | meaning
// IDLE  | counter is 0, waiting for a start pulse
// BUSY  | counter nonzero, decrementing once per cycle
module mdu_sched
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam int            CW       = mdu_cnt_width(MDU_LAT);
  localparam logic [0:0]    ST_IDLE  = MDU_IDLE;
  localparam logic [0:0]    ST_BUSY  = MDU_BUSY;
  localparam logic [CW-1:0] LAT_LOAD = CW'(MDU_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [0:0]    state;
  logic [CW-1:0] mdu_cnt;

  // A branch flush does not reach here: an issued MDU operation always completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mdu_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mdu_cnt <= LAT_LOAD;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          mdu_cnt <= mdu_cnt - CNT_ONE;
          if (mdu_cnt == CNT_ONE) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (mdu_cnt != '0);

  // A second issue while busy is prevented by the ID stall; it is ignored if it slips through
  a_no_start_while_busy : assert property (@(posedge clk) disable iff (rst) !(start && busy))
    else $warning("mdu_sched: start while busy ignored");

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, MDU stall window and stall counter.
// Build option HAZARD_CTRL_MDU_EN enables the MDU scheduler and the MDU hazard.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEFAULT,
  parameter int PERF_W  = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  logic              lu;
  logic              mh;
  logic              stall;
  logic              mdu_busy;
  logic [PERF_W-1:0] stall_cnt;

  assign lu = bus.ex_mem_read && (bus.ex_rt != ZERO_REG) &&
              ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt)) ||
               (bus.id_uses_rt && (bus.id_rt == bus.ex_rt)));

`ifdef HAZARD_CTRL_MDU_EN
  mdu_sched #(
    .MDU_LAT(MDU_LAT)
  ) u_mdu_sched (
    .clk   (clk),
    .rst   (rst),
    .start (bus.ex_mdu_start),
    .busy  (mdu_busy)
  );

  assign mh = mdu_busy && (bus.id_mdu_read || bus.id_mdu_op);
`else
  localparam int UNUSED_MDU_LAT = MDU_LAT;
  logic unused_mdu;
  assign unused_mdu = ^{bus.ex_mdu_start, bus.id_mdu_read, bus.id_mdu_op};
  assign mdu_busy   = 1'b0;
  assign mh         = 1'b0;
`endif

  // A taken branch wins: the stalled ID instruction is on the wrong path anyway
  assign stall = (lu || mh) && !bus.ex_branch_taken;

  assign bus.pc_stall    = stall && !rst;
  assign bus.if_stall    = stall && !rst;
  assign bus.if_flush    = bus.ex_branch_taken || rst;
  assign bus.id_ex_flush = (stall || bus.ex_branch_taken) && !rst;
  assign bus.mdu_busy    = mdu_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (bus.pc_stall) stall_cnt <= stall_cnt + PERF_W'(1);
  end

  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus MDU, wrap and reset sequences.
module tb_hazard_ctrl;

  localparam int LAT = 4;
  localparam int PW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [PW-1:0] exp_sc = '0;

  hazard_ctrl_if #(.PERF_W(PW)) bus ();

  hazard_ctrl #(.MDU_LAT(LAT), .PERF_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mem_read;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       br;
    logic       mdu_read;
    logic       e_stall;
    logic       e_iflush;
    logic       e_idex;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_rt = 5'd0;
    bus.ex_branch_taken = 1'b0; bus.ex_mdu_start = 1'b0;
    bus.id_mdu_read = 1'b0; bus.id_mdu_op = 1'b0;
  endtask

  task automatic chk_ctrl(input string tag, input logic e_stall, input logic e_iflush,
                          input logic e_idex);
    chk({tag, ".pc_stall"}, 32'(bus.pc_stall), 32'(e_stall));
    chk({tag, ".if_stall"}, 32'(bus.if_stall), 32'(e_stall));
    chk({tag, ".if_flush"}, 32'(bus.if_flush), 32'(e_iflush));
    chk({tag, ".id_ex_flush"}, 32'(bus.id_ex_flush), 32'(e_idex));
  endtask

  // One clock with the current inputs; stall counter model follows the expected stall
  task automatic step_check(input string tag, input logic e_stall, input logic e_iflush,
                            input logic e_idex, input logic e_busy);
    @(negedge clk);
    chk_ctrl(tag, e_stall, e_iflush, e_idex);
    chk({tag, ".mdu_busy"}, 32'(bus.mdu_busy), 32'(e_busy));
    if (e_stall) exp_sc = exp_sc + 1'b1;
    tick();
  endtask

  initial begin
    //          mrd  ex_rt  rs     rt     urs   urt   br    mrd  | stall iflush idex
    vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd8,  5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 5'd8,  5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 5'd8,  5'd8,  5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 5'd17, 5'd2,  5'd17, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 5'd17, 5'd16, 5'd18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5'd8,  5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 5'd31, 5'd30, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with a live load-use on the inputs: controls must still be forced
    idle_inputs();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8; bus.id_uses_rs = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk_ctrl("reset", 1'b0, 1'b1, 1'b0);
    chk("reset.mdu_busy", 32'(bus.mdu_busy), 32'd0);
    chk("reset.stall_cycles", 32'(bus.stall_cycles), 32'd0);
    tick(); tick();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    tick();

    for (int i = 0; i < 12; i++) begin
      bus.ex_mem_read     = vecs[i].mem_read;
      bus.ex_rt           = vecs[i].ex_rt;
      bus.id_rs           = vecs[i].rs;
      bus.id_rt           = vecs[i].rt;
      bus.id_uses_rs      = vecs[i].uses_rs;
      bus.id_uses_rt      = vecs[i].uses_rt;
      bus.ex_branch_taken = vecs[i].br;
      bus.id_mdu_read     = vecs[i].mdu_read;
      step_check($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_iflush, vecs[i].e_idex, 1'b0);
      chk($sformatf("vec%0d.stall_cycles", i), 32'(bus.stall_cycles), 32'(exp_sc));
    end
    idle_inputs();

    // Load-use lasts one cycle: load moves on to MEM and the hazard clears
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8; bus.id_uses_rs = 1'b1;
    step_check("lu_c0", 1'b1, 1'b0, 1'b1, 1'b0);
    bus.ex_mem_read = 1'b0; bus.ex_rt = 5'd9;
    step_check("lu_c1", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu.stall_cycles", 32'(bus.stall_cycles), 32'(exp_sc));
    idle_inputs();

    // MDU start, then a dependent mfhi held in ID
    bus.ex_mdu_start = 1'b1;
    tick();
    bus.ex_mdu_start = 1'b0;
    bus.id_mdu_read  = 1'b1;
`ifdef HAZARD_CTRL_MDU_EN
    for (int i = 0; i < LAT; i++) step_check($sformatf("mfhi_c%0d", i), 1'b1, 1'b0, 1'b1, 1'b1);
    step_check("mfhi_release", 1'b0, 1'b0, 1'b0, 1'b0);
`else
    for (int i = 0; i <= LAT; i++) step_check($sformatf("mfhi_c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    chk("mfhi.stall_cycles", 32'(bus.stall_cycles), 32'(exp_sc));
    idle_inputs();

    // Back-to-back mult with a taken branch inside the busy window
    bus.ex_mdu_start = 1'b1;
    tick();
    bus.ex_mdu_start = 1'b0;
    bus.id_mdu_op    = 1'b1;
`ifdef HAZARD_CTRL_MDU_EN
    step_check("b2b_c0", 1'b1, 1'b0, 1'b1, 1'b1);
    bus.ex_branch_taken = 1'b1;
    step_check("b2b_br", 1'b0, 1'b1, 1'b1, 1'b1);
    bus.ex_branch_taken = 1'b0;
    step_check("b2b_c2", 1'b1, 1'b0, 1'b1, 1'b1);
    step_check("b2b_c3", 1'b1, 1'b0, 1'b1, 1'b1);
    step_check("b2b_release", 1'b0, 1'b0, 1'b0, 1'b0);
`else
    step_check("b2b_c0", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.ex_branch_taken = 1'b1;
    step_check("b2b_br", 1'b0, 1'b1, 1'b1, 1'b0);
    bus.ex_branch_taken = 1'b0;
    step_check("b2b_c2", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    chk("b2b.stall_cycles", 32'(bus.stall_cycles), 32'(exp_sc));
    idle_inputs();

    // Counter wraps modulo 2^PW under a held load-use hazard
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rt = 5'd5; bus.id_uses_rt = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    exp_sc = exp_sc + PW'(300);
    @(negedge clk);
    chk("wrap.stall_cycles", 32'(bus.stall_cycles), 32'(exp_sc));
    idle_inputs();
    tick();

    // Asynchronous reset while the MDU counter is at 2
    bus.ex_mdu_start = 1'b1;
    tick();
    bus.ex_mdu_start = 1'b0;
    bus.id_mdu_read  = 1'b1;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.mdu_busy", 32'(bus.mdu_busy), 32'd0);
    chk("rst_mid.stall_cycles", 32'(bus.stall_cycles), 32'd0);
    chk_ctrl("rst_mid", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_sc = '0;
    #1;
    chk_ctrl("post_rst", 1'b0, 1'b0, 1'b0);
    chk("post_rst.mdu_busy", 32'(bus.mdu_busy), 32'd0);
    tick();
    chk("post_rst.stall_cycles", 32'(bus.stall_cycles), 32'(exp_sc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It generates the PC hold, the IF_ID hold (`if_stall`) and the IF_ID flush (`if_flush`, driven into the IF_ID `rst`). It also generates the ID_EX bubble. It detects load-use hazards and resolves taken-branch flushes. It sequences the stall window of the multi-cycle multiply/divide unit and keeps a stall-cycle performance counter. It sits beside the IF, ID and EX stage registers, and every stage register takes its hold/flush controls from here.

## Interface
Parameters:
- `MDU_LAT`, 32: number of cycles the MDU is busy after a start pulse, from 1 to 64.
- `PERF_W`, 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  core clock. All state updates on the posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `id_rs`, `id_rt`  in  5 each  source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  in  1 each  the ID instruction actually reads that source.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_rt`  in  5  destination register of the EX load.
- `ex_branch_taken`  in  1  the branch or jump in EX resolved as taken.
- `ex_mdu_start`  in  1  a mult/div is issuing into the MDU this cycle (one-cycle pulse).
- `id_mdu_read`  in  1  the ID instruction is mfhi or mflo.
- `id_mdu_op`  in  1  the ID instruction is mult or div.
- `pc_stall`  out  1  hold the PC.
- `if_stall`  out  1  hold IF_ID.
- `if_flush`  out  1  clear IF_ID to pc_plus_4 = 32'h3000 and instruction = 0.
- `id_ex_flush`  out  1  insert a bubble into ID_EX.
- `mdu_busy`  out  1  the MDU counter is nonzero.
- `stall_cycles`  out  PERF_W  number of cycles in which `pc_stall` was 1.

## Operation
- **Load-use hazard (`lu`):** `ex_mem_read` is 1, `ex_rt` is not 0, and either (`id_uses_rs` and `id_rs` equals `ex_rt`) or (`id_uses_rt` and `id_rt` equals `ex_rt`).
- **MDU hazard (`mh`):** `mdu_busy` is 1 and (`id_mdu_read` or `id_mdu_op`).
- **Stall (`stall`):** (`lu` or `mh`) and not `ex_branch_taken`.
- **Output equations:**
  - `pc_stall` = `if_stall` = `stall`.
  - `if_flush` = `ex_branch_taken`.
  - `id_ex_flush` = `stall` or `ex_branch_taken`.
- **Priority:** a taken branch beats any stall, because the stalled instruction is on the wrong path. `if_stall` and `if_flush` are never both 1.
- **MDU state machine**, counter `mdu_cnt` of width ceil(log2(MDU_LAT+1)):
  - IDLE (`mdu_cnt` = 0): on `ex_mdu_start`, load `mdu_cnt` with MDU_LAT and go to BUSY.
  - BUSY: decrement `mdu_cnt` each cycle. Return to IDLE when it reaches 0.
  - `ex_mdu_start` while in BUSY cannot occur, because `mh` stalls a second mult/div in ID. If it does occur, ignore it and flag it in simulation only.
  - `ex_branch_taken` does not abort BUSY: the MDU operation already issued and must complete.
- `mdu_busy` = (`mdu_cnt` is not 0).
- `stall_cycles` increments on each posedge where `pc_stall` is 1. It wraps modulo 2^PERF_W.

## Timing
- **Latency:** outputs are combinational from the inputs and the registered `mdu_cnt`. They must settle within half a cycle, because IF_ID samples on the negedge.
- **Load-use stall length:** exactly 1 cycle. On the next cycle the load has moved to MEM, `lu` drops, and forwarding covers the remaining dependency.
- **MDU stall:**
  - `ex_mdu_start` at posedge N leaves `mdu_busy` high for cycles N+1 through N+MDU_LAT.
  - A dependent mfhi/mflo in ID stalls for all of those cycles and proceeds in cycle N+MDU_LAT+1.
- **Reset (asynchronous):**
  - `mdu_cnt` = 0, `stall_cycles` = 0, `mdu_busy` = 0.
  - While `rst` is high, `pc_stall`, `if_stall` and `id_ex_flush` are forced to 0 and `if_flush` is forced to 1.
  - Reset during BUSY abandons the MDU sequence immediately.

## Configuration
- **`HAZARD_CTRL_MDU_EN` defined:** the MDU state machine and `mh` are present as described.
- **`HAZARD_CTRL_MDU_EN` undefined:**
  - `mdu_cnt` is removed and `mdu_busy` is constant 0.
  - `ex_mdu_start`, `id_mdu_read` and `id_mdu_op` are ignored.
  - The ports remain so that the top level is unchanged.

## Structure
- The shared package `pipe_pkg` holds:
  - the reset PC constant (32'h3000);
  - the zero-register constant (5'd0);
  - the MDU state enum {IDLE, BUSY};
  - the default value of MDU_LAT.
- One sub-module, `mdu_sched`, contains the MDU counter and state machine and produces `mdu_busy`. It is instantiated only under `HAZARD_CTRL_MDU_EN`.

## Test plan
- **Load-use:** `ex_mem_read`=1, `ex_rt`=8, `id_rs`=8, `id_uses_rs`=1 → `pc_stall`, `if_stall` and `id_ex_flush` are 1 for exactly one cycle, and `stall_cycles` becomes 1. Repeat with `ex_rt`=0 → no stall.
- **Branch over load-use:** the same load-use condition plus `ex_branch_taken`=1 → `if_flush`=1, `id_ex_flush`=1, `if_stall`=0, `pc_stall`=0.
- **MDU read:** MDU_LAT=4, `ex_mdu_start` pulse, then `id_mdu_read`=1 held → stall for 4 cycles, released on the 5th, `stall_cycles`=4.
- **Back-to-back mult/div:** `id_mdu_op`=1 while `mdu_busy` → stalled until `mdu_busy` drops. An `ex_branch_taken` during BUSY → the counter keeps decrementing.
- **Reset mid-BUSY:** assert `rst` asynchronously at `mdu_cnt`=2 → `mdu_busy`=0 and `stall_cycles`=0 immediately, and `if_flush`=1 while `rst` is high.
- **Build without `HAZARD_CTRL_MDU_EN`:** `ex_mdu_start` followed by `id_mdu_read` → no stall.
